// File: rtl/rd_ddr_resp_if.sv
// Signal bundle between the line-read requester, rd_ddr_resp and the AXI4 read channels.
// The master modport is the responder's view; slave is the view of everything around it.
interface rd_ddr_resp_if #(
    parameter int ADDR_WIDTH = 27,
    parameter int DQ_WIDTH   = 32,
    parameter int LEN_WIDTH  = 16
);
    logic                    ddr_rreq;
    logic [ADDR_WIDTH-1:0]   ddr_raddr;
    logic [LEN_WIDTH-1:0]    ddr_rd_len;
    logic                    ddr_rrdy;
    logic                    ddr_rdone;
    logic [8*DQ_WIDTH-1:0]   ddr_rdata;
    logic                    ddr_rdata_en;
    logic                    req_drop;
    logic                    rlast_err;
    logic [ADDR_WIDTH-1:0]   axi_araddr;
    logic [7:0]              axi_arlen;
    logic                    axi_arvalid;
    logic                    axi_arready;
    logic [8*DQ_WIDTH-1:0]   axi_rdata;
    logic                    axi_rvalid;
    logic                    axi_rlast;
    logic                    axi_rready;

    modport master (
        input  ddr_rreq, ddr_raddr, ddr_rd_len,
        output ddr_rrdy, ddr_rdone, ddr_rdata, ddr_rdata_en, req_drop, rlast_err,
        output axi_araddr, axi_arlen, axi_arvalid, axi_rready,
        input  axi_arready, axi_rdata, axi_rvalid, axi_rlast
    );

    modport slave (
        output ddr_rreq, ddr_raddr, ddr_rd_len,
        input  ddr_rrdy, ddr_rdone, ddr_rdata, ddr_rdata_en, req_drop, rlast_err,
        input  axi_araddr, axi_arlen, axi_arvalid, axi_rready,
        output axi_arready, axi_rdata, axi_rvalid, axi_rlast
    );
endinterface

// File: rtl/rd_ddr_resp.sv
// Line-read responder: splits one request into AXI4 read bursts of up to BURST_MAX beats
// and streams the returned beats back with one cycle of latency, then pulses ddr_rdone.
module rd_ddr_resp #(
    parameter int ADDR_WIDTH = 27,
    parameter int DQ_WIDTH   = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int BURST_MAX  = 16,
    parameter int ADDR_STEP  = 8
) (
    input  logic          ddr_clk,
    input  logic          ddr_rstn,
    rd_ddr_resp_if.master bus
);
    localparam int BEAT_W = 8 * DQ_WIDTH;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]  remain_q, remain_d;
    logic [8:0]            beat_cnt_q, beat_cnt_d;
    logic [BEAT_W-1:0]     rdata_q, rdata_d;
    logic                  rdata_en_q, rdata_en_d;
    logic                  rdone_q, rdone_d;
    logic                  req_drop_q, req_drop_d;
    logic                  rlast_err_q, rlast_err_d;

    logic [8:0]            burst_beats;
    logic [ADDR_WIDTH-1:0] burst_span;

    always_comb begin
        if (remain_q >= LEN_WIDTH'(BURST_MAX)) begin
            burst_beats = 9'(BURST_MAX);
        end else begin
            burst_beats = 9'(remain_q);
        end
        burst_span = ADDR_WIDTH'(burst_beats) * ADDR_WIDTH'(ADDR_STEP);
    end

    always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
        if (!ddr_rstn) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remain_q    <= '0;
            beat_cnt_q  <= '0;
            rdata_q     <= '0;
            rdata_en_q  <= 1'b0;
            rdone_q     <= 1'b0;
            req_drop_q  <= 1'b0;
            rlast_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remain_q    <= remain_d;
            beat_cnt_q  <= beat_cnt_d;
            rdata_q     <= rdata_d;
            rdata_en_q  <= rdata_en_d;
            rdone_q     <= rdone_d;
            req_drop_q  <= req_drop_d;
            rlast_err_q <= rlast_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remain_d    = remain_q;
        beat_cnt_d  = beat_cnt_q;
        rdata_d     = rdata_q;
        rdata_en_d  = 1'b0;
        rdone_d     = 1'b0;
        req_drop_d  = req_drop_q;
        rlast_err_d = rlast_err_q;

        if (bus.ddr_rreq && (state_q != IDLE)) begin
            req_drop_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.ddr_rreq) begin
                    if (bus.ddr_rd_len != '0) begin
                        cur_addr_d = bus.ddr_raddr;
                        remain_d   = bus.ddr_rd_len;
                        state_d    = ADDR;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ADDR: begin
                if (bus.axi_arready) begin
                    beat_cnt_d = burst_beats;
                    cur_addr_d = cur_addr_q + burst_span;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (bus.axi_rvalid) begin
                    rdata_d    = bus.axi_rdata;
                    rdata_en_d = 1'b1;
                    beat_cnt_d = beat_cnt_q - 9'd1;
                    remain_d   = remain_q - LEN_WIDTH'(1);
                    // The beat count decides where the burst ends; rlast is only cross-checked.
                    if (beat_cnt_q == 9'd1) begin
                        if (!bus.axi_rlast) begin
                            rlast_err_d = 1'b1;
                        end
                        state_d = (remain_q != LEN_WIDTH'(1)) ? ADDR : DONE;
                    end else if (bus.axi_rlast) begin
                        rlast_err_d = 1'b1;
                    end
                end
            end
            DONE: begin
                rdone_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // rdone is registered out of DONE so it lands one cycle after the final rdata_en.
    assign bus.ddr_rrdy     = (state_q == IDLE) && !rdone_q;
    assign bus.ddr_rdone    = rdone_q;
    assign bus.ddr_rdata    = rdata_q;
    assign bus.ddr_rdata_en = rdata_en_q;
    assign bus.req_drop     = req_drop_q;
    assign bus.rlast_err    = rlast_err_q;
    assign bus.axi_arvalid  = (state_q == ADDR);
    assign bus.axi_araddr   = (state_q == ADDR) ? cur_addr_q : '0;
    assign bus.axi_arlen    = (state_q == ADDR) ? 8'(burst_beats - 9'd1) : '0;
    assign bus.axi_rready   = (state_q == DATA);
endmodule

// File: tb/tb_rd_ddr_resp.sv
// Scoreboard bench for rd_ddr_resp: expected AR bursts and data beats are queued when a
// request is issued, a simple AXI read slave answers bursts, and a monitor pops and compares.
module tb_rd_ddr_resp;
    localparam int AW   = 27;
    localparam int DQ   = 32;
    localparam int LW   = 16;
    localparam int BW   = 8 * DQ;
    localparam int BM   = 16;
    localparam int STEP = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    rd_ddr_resp_if #(.ADDR_WIDTH(AW), .DQ_WIDTH(DQ), .LEN_WIDTH(LW)) bus ();

    rd_ddr_resp #(
        .ADDR_WIDTH(AW), .DQ_WIDTH(DQ), .LEN_WIDTH(LW), .BURST_MAX(BM), .ADDR_STEP(STEP)
    ) dut (
        .ddr_clk (clk),
        .ddr_rstn(rstn),
        .bus     (bus)
    );

    typedef struct {logic [AW-1:0] addr; logic [7:0] len;} ar_t;
    typedef struct {logic [AW-1:0] addr; int beats;} burst_t;

    int checks   = 0;
    int failures = 0;
    ar_t           exp_ar[$];
    logic [BW-1:0] exp_data[$];
    int n_rdata = 0, n_rdone = 0, n_ar = 0, n_arv = 0;
    bit len0_mode = 1'b0;
    int ar_delay = 0, gap_pct = 0, early_beat = -1;
    bit flush = 1'b0;

    function automatic logic [BW-1:0] beat_data(input logic [AW-1:0] a);
        logic [31:0] w;
        w = {5'b0, a} ^ 32'h5A00_0000;
        return {w, ~w, w + 32'd1, ~w, w + 32'd2, ~w, w + 32'd3, ~w};
    endfunction

    task automatic push_req(input logic [AW-1:0] a, input int len);
        logic [AW-1:0] ca;
        int rem, b;
        ar_t t;
        for (int i = 0; i < len; i++) exp_data.push_back(beat_data(a + AW'(i * STEP)));
        ca  = a;
        rem = len;
        while (rem > 0) begin
            b      = (rem > BM) ? BM : rem;
            t.addr = ca;
            t.len  = 8'(b - 1);
            exp_ar.push_back(t);
            ca  = ca + AW'(b * STEP);
            rem = rem - b;
        end
    endtask

    task automatic pulse_req(input logic [AW-1:0] a, input int len);
        @(posedge clk); #1;
        bus.ddr_rreq   = 1'b1;
        bus.ddr_raddr  = a;
        bus.ddr_rd_len = LW'(len);
        @(posedge clk); #1;
        bus.ddr_rreq   = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] a, input int len);
        push_req(a, len);
        pulse_req(a, len);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int s;
        bit ok;
        s  = n_rdone;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (n_rdone != s) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_timeout: rdone seen %0d, required 1", tag, n_rdone - s);
        end
        repeat (3) @(posedge clk);
    endtask

    // AXI read slave
    initial begin
        burst_t bq[$];
        ar_t t;
        int beat_idx, ar_wait;
        bit ar_hs, r_hs;
        logic [AW-1:0] ar_a;
        logic [7:0] ar_l;
        beat_idx = 0;
        ar_wait  = 0;
        bus.axi_arready = 1'b0;
        bus.axi_rvalid  = 1'b0;
        bus.axi_rlast   = 1'b0;
        bus.axi_rdata   = '0;
        forever begin
            @(negedge clk);
            ar_hs = rstn && bus.axi_arvalid && bus.axi_arready;
            r_hs  = rstn && bus.axi_rvalid && bus.axi_rready;
            ar_a  = bus.axi_araddr;
            ar_l  = bus.axi_arlen;
            @(posedge clk); #1;
            if (flush) begin
                bq.delete();
                beat_idx = 0;
                ar_wait  = 0;
                bus.axi_arready = 1'b0;
                bus.axi_rvalid  = 1'b0;
                bus.axi_rlast   = 1'b0;
            end else begin
                if (ar_hs) begin
                    n_ar++;
                    checks++;
                    if (exp_ar.size() == 0) begin
                        failures++;
                        $display("FAIL ar_unexpected: got addr=%h len=%0d, required none", ar_a, ar_l);
                    end else begin
                        t = exp_ar.pop_front();
                        if ({ar_a, ar_l} !== {t.addr, t.len}) begin
                            failures++;
                            $display("FAIL ar_burst: got addr=%h len=%0d, required addr=%h len=%0d",
                                     ar_a, ar_l, t.addr, t.len);
                        end
                    end
                    bq.push_back('{addr: ar_a, beats: int'(ar_l) + 1});
                    ar_wait = 0;
                end
                if (r_hs && bq.size() > 0) begin
                    beat_idx++;
                    if (beat_idx == bq[0].beats) begin
                        void'(bq.pop_front());
                        beat_idx = 0;
                    end
                end
                if (bus.axi_arvalid && !ar_hs) begin
                    if (ar_wait >= ar_delay) begin
                        bus.axi_arready = 1'b1;
                    end else begin
                        bus.axi_arready = 1'b0;
                        ar_wait++;
                    end
                end else begin
                    bus.axi_arready = 1'b0;
                end
                if (!bus.axi_rvalid || r_hs) begin
                    if (bq.size() == 0 || int'($urandom_range(99)) < gap_pct) begin
                        bus.axi_rvalid = 1'b0;
                        bus.axi_rlast  = 1'b0;
                    end else begin
                        bus.axi_rvalid = 1'b1;
                        bus.axi_rdata  = beat_data(bq[0].addr + AW'(beat_idx * STEP));
                        bus.axi_rlast  = (beat_idx == bq[0].beats - 1) || (beat_idx == early_beat);
                    end
                end
            end
        end
    end

    // Output monitor: data scoreboard, rdone placement, AR stability while stalled
    initial begin
        bit prev_en, prev_arv, prev_hs;
        logic [AW-1:0] pa;
        logic [7:0] pl;
        logic [BW-1:0] e;
        prev_en = 1'b0; prev_arv = 1'b0; prev_hs = 1'b0;
        pa = '0; pl = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_en = 1'b0; prev_arv = 1'b0; prev_hs = 1'b0;
            end else begin
                if (bus.ddr_rdata_en) begin
                    n_rdata++;
                    checks++;
                    if (exp_data.size() == 0) begin
                        failures++;
                        $display("FAIL rdata_unexpected: got %h, required no beat", bus.ddr_rdata);
                    end else begin
                        e = exp_data.pop_front();
                        if (bus.ddr_rdata !== e) begin
                            failures++;
                            $display("FAIL rdata: got %h, required %h", bus.ddr_rdata, e);
                        end
                    end
                end
                if (bus.ddr_rdone) begin
                    n_rdone++;
                    checks++;
                    if (bus.ddr_rdata_en || (!len0_mode && !prev_en) || exp_data.size() != 0) begin
                        failures++;
                        $display("FAIL rdone_timing: rdata_en=%0b prev_en=%0b beats_left=%0d, required 0/1/0",
                                 bus.ddr_rdata_en, prev_en, exp_data.size());
                    end
                end
                if (prev_arv && !prev_hs) begin
                    checks++;
                    if ({bus.axi_arvalid, bus.axi_araddr, bus.axi_arlen} !== {1'b1, pa, pl}) begin
                        failures++;
                        $display("FAIL ar_stable: got v=%0b addr=%h len=%0d, required v=1 addr=%h len=%0d",
                                 bus.axi_arvalid, bus.axi_araddr, bus.axi_arlen, pa, pl);
                    end
                end
                if (bus.axi_arvalid) n_arv++;
                prev_en  = bus.ddr_rdata_en;
                prev_arv = bus.axi_arvalid;
                prev_hs  = bus.axi_arvalid && bus.axi_arready;
                pa       = bus.axi_araddr;
                pl       = bus.axi_arlen;
            end
        end
    end

    task automatic test_reset();
        logic [6:0] flags;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        flags = {bus.ddr_rrdy, bus.ddr_rdone, bus.ddr_rdata_en, bus.req_drop,
                 bus.rlast_err, bus.axi_arvalid, bus.axi_rready};
        checks++;
        if (flags !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_flags: got %b, required 1000000", flags);
        end
        checks++;
        if ({bus.axi_araddr, bus.axi_arlen} !== '0 || bus.ddr_rdata !== '0) begin
            failures++;
            $display("FAIL reset_buses: got araddr=%h arlen=%0d rdata_nonzero=%0b, required 0",
                     bus.axi_araddr, bus.axi_arlen, bus.ddr_rdata != '0);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ddr_rrdy !== 1'b1) begin
            failures++;
            $display("FAIL idle_rrdy: got %b, required 1", bus.ddr_rrdy);
        end
    endtask

    task automatic test_transfer(input string tag, input logic [AW-1:0] a, input int len, input int bursts);
        int sd, sa, sr;
        sd = n_rdata; sa = n_ar; sr = n_rdone;
        issue(a, len);
        wait_done(4000, tag);
        checks++;
        if ({n_rdata - sd, n_ar - sa, n_rdone - sr} !== {len, bursts, 1}) begin
            failures++;
            $display("FAIL %s_counts: got beats=%0d bursts=%0d rdone=%0d, required %0d/%0d/1",
                     tag, n_rdata - sd, n_ar - sa, n_rdone - sr, len, bursts);
        end
        checks++;
        if (exp_data.size() != 0 || exp_ar.size() != 0 || bus.rlast_err !== 1'b0) begin
            failures++;
            $display("FAIL %s_residue: got data_left=%0d ar_left=%0d rlast_err=%b, required 0/0/0",
                     tag, exp_data.size(), exp_ar.size(), bus.rlast_err);
        end
    endtask

    task automatic test_zero_len();
        int low, arv, sr;
        low = 0; arv = 0; sr = n_rdone;
        len0_mode = 1'b1;
        @(posedge clk); #1;
        bus.ddr_rreq   = 1'b1;
        bus.ddr_raddr  = 27'h0ABC;
        bus.ddr_rd_len = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!bus.ddr_rrdy) low++;
            if (bus.axi_arvalid) arv++;
            if (i == 0) begin
                @(posedge clk); #1;
                bus.ddr_rreq = 1'b0;
            end
        end
        checks++;
        if ({low, arv, n_rdone - sr} !== {32'd2, 32'd0, 32'd1}) begin
            failures++;
            $display("FAIL zero_len: got rrdy_low=%0d arvalid=%0d rdone=%0d, required 2/0/1",
                     low, arv, n_rdone - sr);
        end
        len0_mode = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_single_gap();
        int sv, sd;
        sv = n_arv; sd = n_rdata;
        ar_delay = 5;
        gap_pct  = 50;
        issue(27'h0040, 1);
        wait_done(300, "single");
        checks++;
        if ({n_arv - sv, n_rdata - sd} !== {32'd6, 32'd1}) begin
            failures++;
            $display("FAIL single_gap: got arvalid_cycles=%0d beats=%0d, required 6/1",
                     n_arv - sv, n_rdata - sd);
        end
        ar_delay = 0;
        gap_pct  = 0;
    endtask

    task automatic test_drop();
        int sd, sa;
        bit seen;
        sd = n_rdata; sa = n_ar; seen = 1'b0;
        issue(27'h3000, 16);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.axi_rready) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL drop_no_data_phase: rready never seen, required 1");
        end
        pulse_req(27'h7777, 5);
        wait_done(300, "drop");
        checks++;
        if ({bus.req_drop, bus.rlast_err, n_rdata - sd, n_ar - sa} !== {1'b1, 1'b0, 32'd16, 32'd1}) begin
            failures++;
            $display("FAIL drop: got req_drop=%b rlast_err=%b beats=%0d bursts=%0d, required 1/0/16/1",
                     bus.req_drop, bus.rlast_err, n_rdata - sd, n_ar - sa);
        end
    endtask

    task automatic test_rlast_err();
        int sd;
        sd = n_rdata;
        early_beat = 2;
        issue(27'h4000, 16);
        wait_done(300, "rlast");
        checks++;
        if ({bus.rlast_err, n_rdata - sd} !== {1'b1, 32'd16}) begin
            failures++;
            $display("FAIL rlast_early: got rlast_err=%b beats=%0d, required 1/16",
                     bus.rlast_err, n_rdata - sd);
        end
        early_beat = -1;
    endtask

    task automatic test_reset_mid();
        int sd;
        bit ok;
        logic [6:0] flags;
        sd = n_rdata; ok = 1'b0;
        issue(27'h5000, 32);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (n_rdata - sd >= 5) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL midreset_timeout: beats %0d, required 5", n_rdata - sd);
        end
        #1;
        rstn = 1'b0;
        exp_data.delete();
        exp_ar.delete();
        @(negedge clk);
        flags = {bus.ddr_rrdy, bus.ddr_rdone, bus.ddr_rdata_en, bus.req_drop,
                 bus.rlast_err, bus.axi_arvalid, bus.axi_rready};
        checks++;
        if (flags !== 7'b1000000) begin
            failures++;
            $display("FAIL midreset_flags: got %b, required 1000000", flags);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.axi_rready, bus.ddr_rdata_en} !== 2'b00) begin
                failures++;
                $display("FAIL post_reset_beats: got rready=%b rdata_en=%b, required 0/0",
                         bus.axi_rready, bus.ddr_rdata_en);
            end
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        test_transfer("after_reset", 27'h6000, 4, 1);
    endtask

    initial begin
        bus.ddr_rreq   = 1'b0;
        bus.ddr_raddr  = '0;
        bus.ddr_rd_len = '0;
        test_reset();
        test_transfer("line", 27'h0100, 480, 30);
        test_transfer("split", 27'h2000, 20, 2);
        test_zero_len();
        test_single_gap();
        test_drop();
        test_rlast_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
